// File: rtl/mvm_loader.sv
// mvm_loader: write-side front end for the mvm engine.
// Parses one header+payload stream into vector/matrix memory writes and
// start commands, holding a start back while the engine reports busy.
// Optional feature: define MVM_LOADER_STATS_EN to add the o_stat_writes /
// o_stat_starts counters; without it the ports and counters do not exist.
module mvm_loader #(
    parameter int MEM_DATAW     = 64,
    parameter int VEC_MEM_DEPTH = 256,
    parameter int MAT_MEM_DEPTH = 512,
    parameter int NUM_OLANES    = 8,
    localparam int VEC_ADDRW    = $clog2(VEC_MEM_DEPTH),
    localparam int MAT_ADDRW    = $clog2(MAT_MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_DATAW-1:0]  i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [MEM_DATAW-1:0]  o_vec_wdata,
    output logic [VEC_ADDRW-1:0]  o_vec_waddr,
    output logic                  o_vec_wen,
    output logic [MEM_DATAW-1:0]  o_mat_wdata,
    output logic [MAT_ADDRW-1:0]  o_mat_waddr,
    output logic [NUM_OLANES-1:0] o_mat_wen,
    output logic                  o_start,
    output logic [VEC_ADDRW-1:0]  o_vec_start_addr,
    output logic [VEC_ADDRW:0]    o_vec_num_words,
    output logic [MAT_ADDRW-1:0]  o_mat_start_addr,
    output logic [MAT_ADDRW:0]    o_mat_num_rows_per_olane,
    input  logic                  i_mvm_busy,
    output logic                  o_idle,
    output logic                  o_err
`ifdef MVM_LOADER_STATS_EN
    ,
    output logic [31:0]           o_stat_writes,
    output logic [15:0]           o_stat_starts
`endif
);

    // The write cursor is shared by vector and matrix packets, so it is as
    // wide as the wider of the two address spaces.
    localparam int CUR_W = (VEC_ADDRW > MAT_ADDRW) ? VEC_ADDRW : MAT_ADDRW;

    typedef enum logic [2:0] {HDR, VDATA, MDATA, START_WAIT, GUARD} state_t;
    typedef enum logic [1:0] {OP_VEC_WR, OP_MAT_WR, OP_START, OP_RSVD} op_t;

    state_t                state;
    op_t                   hdr_op;
    logic [9:0]            hdr_len;
    logic [9:0]            remaining;
    logic [CUR_W-1:0]      cur_addr;
    logic [CUR_W-1:0]      wrap_limit;
    logic [CUR_W-1:0]      next_addr;
    logic [NUM_OLANES-1:0] lane_mask;
    logic                  beat;

    logic [VEC_ADDRW-1:0]  pend_vec_start;
    logic [VEC_ADDRW:0]    pend_vec_num;
    logic [MAT_ADDRW-1:0]  pend_mat_start;
    logic [MAT_ADDRW:0]    pend_mat_rows;

    assign hdr_op  = op_t'(i_data[1:0]);
    assign hdr_len = i_data[20:11];
    assign o_ready = (state == HDR) || (state == VDATA) || (state == MDATA);
    assign beat    = i_valid && o_ready;
    assign o_idle  = (state == HDR) && !o_vec_wen && (o_mat_wen == '0);

    // Next write address, wrapping at the depth of whichever memory is being filled
    always_comb begin
        wrap_limit = (state == VDATA) ? CUR_W'(VEC_MEM_DEPTH - 1) : CUR_W'(MAT_MEM_DEPTH - 1);
        next_addr  = (cur_addr == wrap_limit) ? '0 : cur_addr + CUR_W'(1);
    end

    // Packet parser FSM with registered write, start and config outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= HDR;
            remaining                <= '0;
            cur_addr                 <= '0;
            lane_mask                <= '0;
            pend_vec_start           <= '0;
            pend_vec_num             <= '0;
            pend_mat_start           <= '0;
            pend_mat_rows            <= '0;
            o_vec_wdata              <= '0;
            o_vec_waddr              <= '0;
            o_vec_wen                <= 1'b0;
            o_mat_wdata              <= '0;
            o_mat_waddr              <= '0;
            o_mat_wen                <= '0;
            o_start                  <= 1'b0;
            o_vec_start_addr         <= '0;
            o_vec_num_words          <= '0;
            o_mat_start_addr         <= '0;
            o_mat_num_rows_per_olane <= '0;
            o_err                    <= 1'b0;
        end else begin
            o_vec_wen <= 1'b0;
            o_mat_wen <= '0;
            o_start   <= 1'b0;
            case (state)
                HDR: begin
                    if (beat) begin
                        case (hdr_op)
                            OP_VEC_WR: begin
                                cur_addr  <= CUR_W'(i_data[2 +: VEC_ADDRW]);
                                remaining <= hdr_len;
                                if (hdr_len != '0) state <= VDATA;
                            end
                            OP_MAT_WR: begin
                                cur_addr  <= CUR_W'(i_data[2 +: MAT_ADDRW]);
                                remaining <= hdr_len;
                                lane_mask <= i_data[21 +: NUM_OLANES];
                                if (hdr_len != '0) state <= MDATA;
                            end
                            OP_START: begin
                                pend_mat_start <= i_data[2 +: MAT_ADDRW];
                                pend_mat_rows  <= i_data[11 +: MAT_ADDRW + 1];
                                pend_vec_start <= i_data[21 +: VEC_ADDRW];
                                pend_vec_num   <= i_data[29 +: VEC_ADDRW + 1];
                                state          <= START_WAIT;
                            end
                            default: o_err <= 1'b1;
                        endcase
                    end
                end
                VDATA: begin
                    if (beat) begin
                        o_vec_wen   <= 1'b1;
                        o_vec_wdata <= i_data;
                        o_vec_waddr <= cur_addr[VEC_ADDRW-1:0];
                        cur_addr    <= next_addr;
                        remaining   <= remaining - 10'd1;
                        if (remaining == 10'd1) state <= HDR;
                    end
                end
                MDATA: begin
                    if (beat) begin
                        o_mat_wen   <= lane_mask;
                        o_mat_wdata <= i_data;
                        o_mat_waddr <= cur_addr[MAT_ADDRW-1:0];
                        cur_addr    <= next_addr;
                        remaining   <= remaining - 10'd1;
                        if (remaining == 10'd1) state <= HDR;
                    end
                end
                START_WAIT: begin
                    if (!i_mvm_busy) begin
                        o_vec_start_addr         <= pend_vec_start;
                        o_vec_num_words          <= pend_vec_num;
                        o_mat_start_addr         <= pend_mat_start;
                        o_mat_num_rows_per_olane <= pend_mat_rows;
                        o_start                  <= 1'b1;
                        state                    <= GUARD;
                    end
                end
                GUARD:   state <= HDR;
                default: state <= HDR;
            endcase
        end
    end

`ifdef MVM_LOADER_STATS_EN
    // Free-running, wrapping counts of write cycles and start pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_writes <= '0;
            o_stat_starts <= '0;
        end else begin
            if (o_vec_wen || (o_mat_wen != '0)) o_stat_writes <= o_stat_writes + 32'd1;
            if (o_start) o_stat_starts <= o_stat_starts + 16'd1;
        end
    end
`endif

endmodule
